// File: rtl/osc_clk_sequencer_if.sv
// Control bundle for the oscillator clock sequencer: divider reconfiguration
// handshake and the DRAM/video hold request.
interface osc_clk_sequencer_if #(
  parameter int unsigned DIV_W = 8
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_cpu_div;
  logic [DIV_W-1:0] cfg_pix_div;
  logic             cfg_ready;
  logic             hold_req;
  logic             hold_ack;

  modport master (
    output cfg_valid,
    output cfg_cpu_div,
    output cfg_pix_div,
    output hold_req,
    input  cfg_ready,
    input  hold_ack
  );

  modport slave (
    input  cfg_valid,
    input  cfg_cpu_div,
    input  cfg_pix_div,
    input  hold_req,
    output cfg_ready,
    output hold_ack
  );
endinterface

// File: rtl/osc_clk_sequencer.sv
// Startup sequencer and CPU/pixel clock-enable generator running off the on-chip
// oscillator: settle wait, system reset stretch, then divided enable strobes.
module osc_clk_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD      = 16,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned CPU_DIV_INIT  = 8,
  parameter int unsigned PIX_DIV_INIT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  osc_clk_sequencer_if.slave    ctrl,
  output logic                  sys_rst_n,
  output logic                  cpu_ce,
  output logic                  pix_ce,
  output logic                  seq_ready
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > RST_HOLD) ? SETTLE_CYCLES : RST_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    StSettle,
    StHold,
    StRun,
    StReconf
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   cpu_div_q, cpu_div_d;
  logic [DIV_W-1:0]   pix_div_q, pix_div_d;
  logic [DIV_W-1:0]   cpu_cnt_q, cpu_cnt_d;
  logic [DIV_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               seq_ready_q, seq_ready_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic               pix_ce_q, pix_ce_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               hold_ack_q, hold_ack_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_div_d   = cpu_div_q;
    pix_div_d   = pix_div_q;
    cpu_cnt_d   = cpu_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    sys_rst_n_d = sys_rst_n_q;
    seq_ready_d = seq_ready_q;
    cpu_ce_d    = 1'b0;
    pix_ce_d    = 1'b0;
    cfg_ready_d = 1'b0;
    hold_ack_d  = 1'b0;

    unique case (state_q)
      StSettle: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d     = StRun;
          cnt_d       = '0;
          sys_rst_n_d = 1'b1;
          seq_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRun: begin
        hold_ack_d = ctrl.hold_req;
        // Reconfiguration wins over hold; counters restart from zero with the new dividers.
        if (ctrl.cfg_valid) begin
          state_d     = StReconf;
          cfg_ready_d = 1'b1;
          cpu_div_d   = ctrl.cfg_cpu_div;
          pix_div_d   = ctrl.cfg_pix_div;
          cpu_cnt_d   = '0;
          pix_cnt_d   = '0;
        end else begin
          pix_ce_d  = (pix_cnt_q == pix_div_q);
          pix_cnt_d = pix_ce_d ? '0 : pix_cnt_q + 1'b1;
          if (!ctrl.hold_req) begin
            cpu_ce_d  = (cpu_cnt_q == cpu_div_q);
            cpu_cnt_d = cpu_ce_d ? '0 : cpu_cnt_q + 1'b1;
          end
        end
      end

      StReconf: begin
        hold_ack_d = ctrl.hold_req;
        state_d    = StRun;
      end

      default: state_d = StSettle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSettle;
      cnt_q       <= '0;
      cpu_div_q   <= DIV_W'(CPU_DIV_INIT);
      pix_div_q   <= DIV_W'(PIX_DIV_INIT);
      cpu_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      sys_rst_n_q <= 1'b0;
      seq_ready_q <= 1'b0;
      cpu_ce_q    <= 1'b0;
      pix_ce_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      hold_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_div_q   <= cpu_div_d;
      pix_div_q   <= pix_div_d;
      cpu_cnt_q   <= cpu_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
      seq_ready_q <= seq_ready_d;
      cpu_ce_q    <= cpu_ce_d;
      pix_ce_q    <= pix_ce_d;
      cfg_ready_q <= cfg_ready_d;
      hold_ack_q  <= hold_ack_d;
    end
  end

  assign sys_rst_n      = sys_rst_n_q;
  assign seq_ready      = seq_ready_q;
  assign cpu_ce         = cpu_ce_q;
  assign pix_ce         = pix_ce_q;
  assign ctrl.cfg_ready = cfg_ready_q;
  assign ctrl.hold_ack  = hold_ack_q;

endmodule

// File: tb/tb_osc_clk_sequencer.sv
// Directed bench for osc_clk_sequencer: per-cycle expected output vectors are queued
// as stimulus is driven and compared once the clock edge has produced the outputs.
module tb_osc_clk_sequencer;
  localparam int unsigned DIV_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sys_rst_n, cpu_ce, pix_ce, seq_ready;

  osc_clk_sequencer_if #(.DIV_W(DIV_W)) bus ();

  osc_clk_sequencer #(
    .SETTLE_CYCLES(8),
    .RST_HOLD     (4),
    .DIV_W        (DIV_W),
    .CPU_DIV_INIT (8),
    .PIX_DIV_INIT (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (bus.slave),
    .sys_rst_n(sys_rst_n),
    .cpu_ce   (cpu_ce),
    .pix_ce   (pix_ce),
    .seq_ready(seq_ready)
  );

  always #5 clk = ~clk;

  // Vector layout: {sys_rst_n, seq_ready, cpu_ce, pix_ce, hold_ack, cfg_ready}
  logic [5:0] exp_q[$];
  string      tag_q[$];
  int vectors = 0;
  int miscompares = 0;
  int pd, cd, pix_n, cpu_phase;

  function automatic logic [5:0] obs();
    return {sys_rst_n, seq_ready, cpu_ce, pix_ce, bus.hold_ack, bus.cfg_ready};
  endfunction

  task automatic tick(input string tag, input logic [5:0] e);
    logic [5:0] exp_v;
    string      t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    vectors++;
    assert (obs() === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", t, obs(), exp_v);
    end
  endtask

  // RUN cadence: ce appears the cycle after the counter reaches its divider.
  task automatic run_tick(input string tag);
    logic pe, ce;
    pe = ((pix_n % (pd + 1)) == pd);
    pix_n++;
    if (bus.hold_req) begin
      ce = 1'b0;
    end else begin
      ce = ((cpu_phase % (cd + 1)) == cd);
      cpu_phase++;
    end
    tick(tag, {2'b11, ce, pe, bus.hold_req, 1'b0});
  endtask

  task automatic run_n(input string tag, input int n);
    for (int i = 0; i < n; i++) run_tick(tag);
  endtask

  // 8 settle + 4 hold edges; the 12th edge enters RUN.
  task automatic startup(input string tag);
    for (int i = 1; i < 12; i++) tick(tag, 6'b000000);
    tick(tag, 6'b110000);
    pix_n     = 0;
    cpu_phase = 0;
    pd        = 3;
    cd        = 8;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    assert (obs() === 6'b000000) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs(), 6'b000000);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_cpu_div = '0;
    bus.cfg_pix_div = '0;
    bus.hold_req    = 1'b0;
    pd = 3; cd = 8; pix_n = 0; cpu_phase = 0;

    tick("reset", 6'b000000);
    tick("reset", 6'b000000);
    rst_n = 1'b1;
    startup("powerup");
    run_n("run_default", 20);

    bus.hold_req = 1'b1;
    run_n("hold", 20);
    bus.hold_req = 1'b0;
    run_n("hold_release", 20);

    bus.cfg_cpu_div = 8'd1;
    bus.cfg_pix_div = 8'd0;
    bus.cfg_valid   = 1'b1;
    tick("cfg_accept", 6'b110001);
    bus.cfg_valid = 1'b0;
    tick("reconf", 6'b110000);
    pd = 0; cd = 1; pix_n = 0; cpu_phase = 0;
    run_n("run_fast", 10);

    async_reset("async_reset_run");
    rst_n = 1'b1;
    startup("restart");
    run_n("run_init", 20);

    // cfg_valid and hold_req held from reset: both ignored until RUN, then reconfig wins.
    async_reset("async_reset_cfg");
    bus.cfg_cpu_div = 8'd2;
    bus.cfg_pix_div = 8'd1;
    bus.cfg_valid   = 1'b1;
    bus.hold_req    = 1'b1;
    rst_n = 1'b1;
    startup("settle_cfg");
    tick("cfg_hold_accept", 6'b110011);
    bus.cfg_valid = 1'b0;
    tick("reconf_hold", 6'b110010);
    pd = 1; cd = 2; pix_n = 0; cpu_phase = 0;
    run_n("held_after_reconf", 6);
    bus.hold_req = 1'b0;
    run_n("release_after_reconf", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
